// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage core: program counter, F/D pipeline latch,
// D/X bubble/flush controls and saturating stall/flush performance counters.
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_lu,
    input  logic              stall_md,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       pc,
    output logic [31:0]       ir_fd,
    output logic [31:0]       pc_fd,
    output logic              valid_fd,
    output logic              bubble_dx,
    output logic              flush_dx,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_fd_q, ir_fd_d;
    logic [31:0] pc_fd_q, pc_fd_d;
    logic        valid_fd_q, valid_fd_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stall_s;

    assign stall_s = stall_lu | stall_md;

    // Next-state selection: redirect beats stall, stall beats advance.
    always_comb begin
        pc_d        = pc_q;
        ir_fd_d     = ir_fd_q;
        pc_fd_d     = pc_fd_q;
        valid_fd_d  = valid_fd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            // Concurrent stalls are discarded: the wrong-path work is being thrown away.
            pc_d        = redirect_pc;
            ir_fd_d     = NOP;
            pc_fd_d     = 32'h0000_0000;
            valid_fd_d  = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (stall_s) begin
            // Hold the front end; imem_addr stays on pc so the same word is refetched.
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            pc_d       = pc_q + 32'd1;
            ir_fd_d    = imem_data;
            pc_fd_d    = pc_q;
            valid_fd_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ir_fd_q     <= NOP;
            pc_fd_q     <= 32'h0000_0000;
            valid_fd_q  <= 1'b0;
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            ir_fd_q     <= ir_fd_d;
            pc_fd_q     <= pc_fd_d;
            valid_fd_q  <= valid_fd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Under a multdiv stall downstream also holds, so no bubble is needed.
    assign bubble_dx = stall_lu & ~stall_md & ~redirect;
    assign flush_dx  = redirect & ~reset;

    // Upper pc bits are retained but never reach the instruction memory.
    assign imem_addr = pc_q[ADDR_W-1:0];
    assign pc        = pc_q;
    assign ir_fd     = ir_fd_q;
    assign pc_fd     = pc_fd_q;
    assign valid_fd  = valid_fd_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
